// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_t;

    localparam int CNT_W   = 16;
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first set request strictly after rr_ptr, wrapping.
module fifo_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   idx,
    output logic               valid
);

    logic [PTR_W-1:0] cand;

    // Visiting rr_ptr itself last gives the previous owner the lowest priority.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst write arbiter in front of a shared sync FIFO.
// Optional FIFO_ARB_STATS_EN adds per-producer beat counters and a stall-cycle counter.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int BURST_MAX  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic                          wr_en,
    output logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          full,
    input  logic                          almostfull,
    input  logic                          wr_ack,
    input  logic                          overflow,
    output logic                          ovf_err
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]      beat_cnt_o,
    output logic [CNT_W-1:0]              stall_cnt_o
`endif
);

    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int BCNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

    arb_state_t          state, state_n;
    logic [PTR_W-1:0]    owner, owner_n;
    logic [PTR_W-1:0]    rr_ptr, rr_n;
    logic [BCNT_W-1:0]   beat_cnt, beat_n;
    logic [NUM_REQ-1:0]  gnt_n;
    logic                wr_en_n;
    logic [FIFO_WIDTH-1:0] data_n;
    logic                accept;
    logic                stall;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_valid;
    logic                vld_d0, wr_en_d1;
    logic [PTR_W-1:0]    own_d0, own_d1;

    fifo_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // almostfull only matters when a write is already in flight on the registered port.
    assign stall = full | (almostfull & wr_en);

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        owner_n = owner;
        rr_n    = rr_ptr;
        beat_n  = beat_cnt;
        wr_en_n = 1'b0;
        data_n  = data_in;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid && !stall) begin
                    state_n = BURST;
                    gnt_n   = NUM_REQ'(onehot(IDX_W'(pick_idx)));
                    owner_n = pick_idx;
                    beat_n  = '0;
                end else begin
                    gnt_n = '0;
                end
            end
            BURST: begin
                if (!req[owner]) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    rr_n    = owner;
                end else if (!stall) begin
                    accept  = 1'b1;
                    wr_en_n = 1'b1;
                    data_n  = req_data[int'(owner)*FIFO_WIDTH +: FIFO_WIDTH];
                    beat_n  = beat_cnt + 1'b1;
                    if (beat_cnt == BCNT_W'(BURST_MAX - 1)) begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        rr_n    = owner;
                        beat_n  = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            rr_ptr   <= PTR_W'(NUM_REQ - 1);
            beat_cnt <= '0;
            wr_en    <= 1'b0;
            data_in  <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            owner    <= owner_n;
            rr_ptr   <= rr_n;
            beat_cnt <= beat_n;
            wr_en    <= wr_en_n;
            data_in  <= data_n;
        end
    end

    // Stage 0 lines up with wr_en, stage 1 with the FIFO's wr_ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_d0   <= 1'b0;
            own_d0   <= '0;
            wr_en_d1 <= 1'b0;
            own_d1   <= '0;
            ovf_err  <= 1'b0;
        end else begin
            vld_d0   <= accept;
            own_d0   <= owner;
            wr_en_d1 <= vld_d0;
            own_d1   <= own_d0;
            ovf_err  <= ovf_err | (overflow & wr_en_d1);
        end
    end

    always_comb begin
        req_ack = '0;
        if (wr_en_d1 && wr_ack)
            req_ack = NUM_REQ'(onehot(IDX_W'(own_d1)));
    end

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] beat_stat;
    logic [CNT_W-1:0]              stall_stat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_stat  <= '0;
            stall_stat <= '0;
        end else begin
            if (accept && beat_stat[owner] != '1)
                beat_stat[owner] <= beat_stat[owner] + 1'b1;
            if (state == BURST && stall && stall_stat != '1)
                stall_stat <= stall_stat + 1'b1;
        end
    end

    assign beat_cnt_o  = beat_stat;
    assign stall_cnt_o = stall_stat;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter; the bench also plays the FIFO's wr_ack.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int W  = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [NR*W-1:0] req_data;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   req_ack;
    logic            wr_en;
    logic [W-1:0]    data_in;
    logic            full;
    logic            almostfull;
    logic            wr_ack = 1'b0;
    logic            overflow;
    logic            ovf_err;
`ifdef FIFO_ARB_STATS_EN
    logic [NR*16-1:0] beat_cnt_o;
    logic [15:0]      stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(.NUM_REQ(NR), .FIFO_WIDTH(W), .BURST_MAX(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .req_ack    (req_ack),
        .wr_en      (wr_en),
        .data_in    (data_in),
        .full       (full),
        .almostfull (almostfull),
        .wr_ack     (wr_ack),
        .overflow   (overflow),
        .ovf_err    (ovf_err)
`ifdef FIFO_ARB_STATS_EN
        ,
        .beat_cnt_o (beat_cnt_o),
        .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // FIFO acknowledges each write one cycle after wr_en.
    always @(posedge clk) wr_ack <= wr_en;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [W-1:0] v);
        req_data[i*W +: W] = v;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        req = '0;
        req_data = '0;
        full = 1'b0;
        almostfull = 1'b0;
        overflow = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b1111;
        req_data = 64'h1111_2222_3333_4444;
        full = 1'b0;
        almostfull = 1'b0;
        overflow = 1'b0;
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0000 || wr_en !== 1'b0 || req_ack !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: gnt=%b wr_en=%b req_ack=%b, expected 0000 0 0000", gnt, wr_en, req_ack);
        end
        checks++;
        if (data_in !== 16'h0000 || ovf_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_data: data_in=%h ovf_err=%b, expected 0000 0", data_in, ovf_err);
        end
        req = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_burst();
        logic [W-1:0] din  [6] = '{16'h00A0, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A3};
        logic [NR-1:0] eg  [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
        logic          ew  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [W-1:0]  ed  [6] = '{16'h0000, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A3};
        logic [NR-1:0] ea  [6] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        reset_dut();
        req = 4'b0001;
        for (int e = 0; e < 6; e++) begin
            set_data(0, din[e]);
            tick();
            checks++;
            if (gnt !== eg[e] || wr_en !== ew[e] || data_in !== ed[e] || req_ack !== ea[e]) begin
                errors++;
                $display("[TB] FAIL single_burst edge %0d: gnt=%b wr_en=%b data_in=%h req_ack=%b, expected %b %b %h %b",
                         e + 1, gnt, wr_en, data_in, req_ack, eg[e], ew[e], ed[e], ea[e]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] oh;
        reset_dut();
        for (int i = 0; i < NR; i++) set_data(i, 16'(16'h1000 * (i + 1)));
        req = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            oh = 4'b0001 << (b % 4);
            tick();
            checks++;
            if (gnt !== oh || wr_en !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rr_grant burst %0d: gnt=%b wr_en=%b, expected %b 0", b, gnt, wr_en, oh);
            end
            for (int k = 1; k <= 4; k++) begin
                tick();
                checks++;
                if (wr_en !== 1'b1 || data_in !== 16'(16'h1000 * ((b % 4) + 1)) ||
                    gnt !== ((k < 4) ? oh : 4'b0000)) begin
                    errors++;
                    $display("[TB] FAIL rr_beat burst %0d beat %0d: gnt=%b wr_en=%b data_in=%h, expected %b 1 %h",
                             b, k, gnt, wr_en, data_in, (k < 4) ? oh : 4'b0000, 16'(16'h1000 * ((b % 4) + 1)));
                end
            end
        end
        req = '0;
    endtask

    task automatic test_full_stall();
        logic [W-1:0] din  [7] = '{16'h00C0, 16'h00C0, 16'h00C1, 16'h00C2, 16'h00C2, 16'h00C2, 16'h00C3};
        logic          ef  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [NR-1:0] eg  [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        logic          ew  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0]  ed  [7] = '{16'h0000, 16'h00C0, 16'h00C1, 16'h00C1, 16'h00C1, 16'h00C2, 16'h00C3};
        reset_dut();
        req = 4'b0100;
        for (int e = 0; e < 7; e++) begin
            set_data(2, din[e]);
            full = ef[e];
            tick();
            checks++;
            if (gnt !== eg[e] || wr_en !== ew[e] || data_in !== ed[e]) begin
                errors++;
                $display("[TB] FAIL full_stall edge %0d: gnt=%b wr_en=%b data_in=%h, expected %b %b %h",
                         e + 1, gnt, wr_en, data_in, eg[e], ew[e], ed[e]);
            end
        end
`ifdef FIFO_ARB_STATS_EN
        checks++;
        if (beat_cnt_o[2*16 +: 16] !== 16'd4 || stall_cnt_o !== 16'd2) begin
            errors++;
            $display("[TB] FAIL stats_full: beats2=%0d stalls=%0d, expected 4 2", beat_cnt_o[2*16 +: 16], stall_cnt_o);
        end
`endif
        req = '0;
    endtask

    task automatic test_almostfull();
        logic [W-1:0] din  [4] = '{16'h00D0, 16'h00D0, 16'h00D1, 16'h00D1};
        logic          eaf [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic          ew  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0]  ed  [4] = '{16'h0000, 16'h00D0, 16'h00D0, 16'h00D1};
        reset_dut();
        req = 4'b0010;
        for (int e = 0; e < 4; e++) begin
            set_data(1, din[e]);
            almostfull = eaf[e];
            tick();
            checks++;
            if (gnt !== 4'b0010 || wr_en !== ew[e] || data_in !== ed[e]) begin
                errors++;
                $display("[TB] FAIL almostfull edge %0d: gnt=%b wr_en=%b data_in=%h, expected 0010 %b %h",
                         e + 1, gnt, wr_en, data_in, ew[e], ed[e]);
            end
        end
        almostfull = 1'b0;
        req = '0;
        tick();
        checks++;
        if (gnt !== 4'b0000 || wr_en !== 1'b0 || ovf_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL af_release: gnt=%b wr_en=%b ovf_err=%b, expected 0000 0 0", gnt, wr_en, ovf_err);
        end
    endtask

    task automatic test_overflow();
        reset_dut();
        req = 4'b0001;
        set_data(0, 16'h00E0);
        overflow = 1'b1;
        tick();
        tick();
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_idle: ovf_err=%b, expected 0", ovf_err);
        end
        tick();
        tick();
        overflow = 1'b0;
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_set: ovf_err=%b, expected 1", ovf_err);
        end
        req = '0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_sticky: ovf_err=%b, expected 1", ovf_err);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_clear: ovf_err=%b, expected 0", ovf_err);
        end
    endtask

    task automatic test_reset_mid_burst();
        reset_dut();
        req = 4'b0100;
        set_data(2, 16'h00F0);
        tick();
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0100 || wr_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_pre: gnt=%b wr_en=%b, expected 0100 1", gnt, wr_en);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0000 || wr_en !== 1'b0 || req_ack !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL mid_reset: gnt=%b wr_en=%b req_ack=%b, expected 0000 0 0000", gnt, wr_en, req_ack);
        end
`ifdef FIFO_ARB_STATS_EN
        checks++;
        if (beat_cnt_o !== '0 || stall_cnt_o !== 16'd0) begin
            errors++;
            $display("[TB] FAIL mid_stats: beats=%h stalls=%0d, expected 0 0", beat_cnt_o, stall_cnt_o);
        end
`endif
        rst_n = 1'b1;
        req = 4'b1111;
        tick();
        checks++;
        if (gnt !== 4'b0001 || req_ack !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL mid_regrant: gnt=%b req_ack=%b, expected 0001 0000", gnt, req_ack);
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_full_stall();
        test_almostfull();
        test_overflow();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
